sr_write_sequencer: RTL
=======================

Name: sr_write_sequencer

Overview:
Upstream feeder for the shift-register read/write top block. It accepts 16-bit configuration words from the control interface over a valid/ready handshake and replays each one as a single-cycle wr_en/din pulse. After exactly NUM_WORDS words have been loaded and go is asserted, it issues a stretched start pulse. It then holds busy for a programmable settle time and signals done. It runs on the same clk_in domain as the shift-register top block.

Parameters:
NUM_WORDS, 11, number of 16-bit words per shift-register frame; ceil(170/16).
CNT_WIDTH, 8, word counter width; NUM_WORDS <= 2**CNT_WIDTH-1.
START_CYCLES, 128, sr_start high time in clk cycles; must be >= 2*2**div of the downstream clock divider.
WAIT_WIDTH, 16, width of the settle counter.

Ports:
clk  in  1  system clock; same as the downstream clk_in.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command word valid.
cmd_data  in  16  command word.
cmd_ready  out  1  sequencer can accept a word.
go  in  1  single-cycle request to start the frame transfer.
abort  in  1  synchronous abort; highest priority after rst.
wait_cycles  in  WAIT_WIDTH  settle time after start; sampled on accepted go.
sr_wr_en  out  1  write strobe to the downstream config word combiner.
sr_din  out  16  word accompanying sr_wr_en.
sr_start  out  1  start to the downstream shift-register block.
busy  out  1  high in the START, WAIT and DONE states.
done  out  1  one-cycle pulse at the end of the frame.
word_count  out  CNT_WIDTH  number of words accepted in the current frame.
err_underflow  out  1  sticky flag: go was received with word_count != NUM_WORDS.

Behaviour:
- Reset values: all outputs 0, cmd_ready 0, state IDLE. On the first cycle after reset release, cmd_ready goes to 1.
- FSM states: IDLE, LOAD, START, WAIT, DONE.
- cmd_ready = 1 in IDLE and LOAD when word_count < NUM_WORDS; otherwise 0. The value is combinational from registered state.
- Accept rule: a word is accepted when cmd_valid & cmd_ready.
  - On the next cycle: sr_wr_en = 1 for exactly 1 cycle, sr_din = the accepted cmd_data, and word_count increments by 1.
  - Latency from accept to strobe is 1 cycle. Back-to-back accepts give back-to-back strobes.
  - The first accept moves IDLE to LOAD.
- When word_count = NUM_WORDS, cmd_ready = 0. Further cmd_valid is held off; no word is lost or dropped.
- sr_din holds its last value between strobes.
- go in IDLE or LOAD:
  - If word_count = NUM_WORDS (registered value, before any same-cycle accept): latch wait_cycles into the settle counter, clear err_underflow, and go to START.
  - Otherwise: set err_underflow, stay in the current state, and leave word_count unchanged.
  - If go and a word accept occur in the same cycle, the go is judged against the pre-accept count and the word is still accepted.
- go in START, WAIT or DONE is ignored; no flag is set.
- START: sr_start = 1 for exactly START_CYCLES consecutive cycles, then go to WAIT. sr_start is registered with no glitches.
- WAIT: the settle counter decrements once per cycle and the FSM exits when the counter is 0. WAIT therefore lasts wait_cycles+1 cycles; wait_cycles = 0 gives 1 cycle. Then go to DONE.
- DONE: 1 cycle. done = 1, word_count cleared to 0, then go to IDLE. cmd_ready returns to 1 on the cycle after DONE.
- abort, in any state:
  - Next cycle: state IDLE, word_count 0, settle and start counters 0, sr_start 0, sr_wr_en 0.
  - No done pulse is generated and err_underflow is unchanged.
  - abort wins over a same-cycle accept or go; that word is discarded and no strobe follows.
- rst mid-frame: all outputs drop immediately (asynchronous). sr_start never remains high across reset.
- busy = 1 exactly in START, WAIT and DONE.
- Counters: the start counter needs ceil(log2(START_CYCLES+1)) bits. No wrap-around is possible because all limits are checked before incrementing.

Test Plan:
1. Reset then 11 back-to-back words 0x0001..0x000B with cmd_valid held high -> 11 consecutive sr_wr_en pulses with sr_din 0x0001..0x000B, each 1 cycle after its accept; word_count = 11; cmd_ready = 0 afterwards.
2. After case 1, go with wait_cycles = 5 -> sr_start high for exactly 128 cycles, then busy for 6 more WAIT cycles, done high for 1 cycle; word_count = 0 and cmd_ready = 1 on the following cycle.
3. go after only 4 words -> err_underflow = 1, no sr_start, word_count stays 4. Load the remaining 7 words and go again -> err_underflow clears and the frame completes normally.
4. 12th word presented with cmd_valid held -> cmd_ready stays 0 and no 12th strobe occurs until DONE. The word is then accepted as word 1 of the next frame.
5. abort asserted at cycle 50 of START -> sr_start = 0 on the next cycle, state IDLE, no done pulse. A subsequent full 11-word frame runs correctly.
6. Asynchronous rst pulse during WAIT -> all outputs 0 immediately; word_count = 0 after release; wait_cycles = 0 frame -> WAIT lasts exactly 1 cycle.

Source files
------------

// File: rtl/sr_write_sequencer_if.sv
// Command word bus into the shift-register write sequencer: a 16-bit word
// moves on a valid/ready handshake.
interface sr_write_sequencer_if;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        cmd_ready;

    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/sr_write_sequencer.sv
// Collects a frame of configuration words, replays each as a wr_en/din strobe,
// then drives a stretched start pulse, a programmable settle time and done.
module sr_write_sequencer #(
    parameter int NUM_WORDS    = 11,
    parameter int CNT_WIDTH    = 8,
    parameter int START_CYCLES = 128,
    parameter int WAIT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sr_write_sequencer_if.slave   cmd,
    input  logic                  go,
    input  logic                  abort,
    input  logic [WAIT_WIDTH-1:0] wait_cycles,
    output logic                  sr_wr_en,
    output logic [15:0]           sr_din,
    output logic                  sr_start,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  err_underflow
);
    localparam int SC_W = $clog2(START_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(NUM_WORDS);
    localparam logic [SC_W-1:0]      START_LAST = SC_W'(START_CYCLES - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [SC_W-1:0]       start_cnt_q, start_cnt_d;
    logic                  sr_wr_en_q, sr_wr_en_d;
    logic [15:0]           sr_din_q, sr_din_d;
    logic                  err_q, err_d;
    logic                  sr_start_q, busy_q, done_q;
    logic                  ready_en_q;
    logic                  cmd_ready_c, accept, frame_full;

    // ready_en_q keeps cmd_ready low while reset is applied and for the
    // release edge itself, even though the state is already IDLE.
    assign frame_full  = (word_count_q == FULL_COUNT);
    assign cmd_ready_c = ready_en_q && (state_q == ST_IDLE || state_q == ST_LOAD)
                         && (word_count_q < FULL_COUNT);
    assign accept      = cmd.cmd_valid && cmd_ready_c;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        wait_cnt_d   = wait_cnt_q;
        start_cnt_d  = start_cnt_q;
        sr_wr_en_d   = 1'b0;
        sr_din_d     = sr_din_q;
        err_d        = err_q;
        if (abort) begin
            state_d      = ST_IDLE;
            word_count_d = '0;
            wait_cnt_d   = '0;
            start_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        sr_wr_en_d   = 1'b1;
                        sr_din_d     = cmd.cmd_data;
                        word_count_d = word_count_q + 1'b1;
                        state_d      = ST_LOAD;
                    end
                    // Judged on the pre-accept count; a full frame never accepts.
                    if (go) begin
                        if (frame_full) begin
                            state_d     = ST_START;
                            wait_cnt_d  = wait_cycles;
                            start_cnt_d = '0;
                            err_d       = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (start_cnt_q == START_LAST) begin
                        state_d     = ST_WAIT;
                        start_cnt_d = '0;
                    end else begin
                        start_cnt_d = start_cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    word_count_d = '0;
                    state_d      = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Status outputs are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            wait_cnt_q   <= '0;
            start_cnt_q  <= '0;
            sr_wr_en_q   <= 1'b0;
            sr_din_q     <= '0;
            err_q        <= 1'b0;
            sr_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            wait_cnt_q   <= wait_cnt_d;
            start_cnt_q  <= start_cnt_d;
            sr_wr_en_q   <= sr_wr_en_d;
            sr_din_q     <= sr_din_d;
            err_q        <= err_d;
            sr_start_q   <= (state_d == ST_START);
            busy_q       <= (state_d == ST_START) || (state_d == ST_WAIT) || (state_d == ST_DONE);
            done_q       <= (state_d == ST_DONE);
            ready_en_q   <= 1'b1;
        end
    end

    assign cmd.cmd_ready  = cmd_ready_c;
    assign sr_wr_en       = sr_wr_en_q;
    assign sr_din         = sr_din_q;
    assign sr_start       = sr_start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign word_count     = word_count_q;
    assign err_underflow  = err_q;
endmodule
